// File: rtl/adc_sample_ctrl.sv
// AD7895 sample sequencer: periodic start strobe, timeout-guarded capture, 2^NAVG_LOG2 boxcar average.
// Define ADC_PEAK_EN to add pk_max, the largest sample of each averaged window.
module adc_sample_ctrl #(
  parameter int DIV       = 1250,
  parameter int NAVG_LOG2 = 2,
  parameter int TMO       = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        st,
  input  logic        ok_adc,
  input  logic [11:0] ADC_dat,
  output logic [11:0] dat_out,
  output logic        dat_valid,
  output logic        busy,
  output logic        overrun,
  output logic        tmo_err,
`ifdef ADC_PEAK_EN
  output logic [11:0] pk_max,
`endif
  input  logic        clr
);

  localparam int CW = $clog2(DIV);
  localparam int WW = $clog2(TMO + 1);
  localparam int AW = 12 + NAVG_LOG2;
  localparam int NW = NAVG_LOG2 + 1;
  localparam logic [NW-1:0] NFULL = NW'(1 << NAVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_LATCH, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] per_q, per_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [11:0]   dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic          tick, tmo_hit;

  assign tick    = en && (per_q == CW'(DIV - 1));
  assign tmo_hit = (state_q == S_WAIT) && !ok_adc && (wait_q == WW'(TMO));
  assign acc_sum = acc_q + AW'(ADC_dat);

  always_comb begin
    state_d = state_q;
    per_d   = (!en || tick) ? '0 : per_q + 1'b1;
    wait_d  = wait_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    ovr_d   = clr ? 1'b0 : ovr_q;
    tmo_d   = clr ? 1'b0 : tmo_q;
    if (tick && state_q != S_IDLE) ovr_d = 1'b1;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_START;
      S_START: begin
        wait_d  = WW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ok_adc) begin
          state_d = S_LATCH;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LATCH: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        // Result registers load on entry to OUT so dat_valid lands two cycles after ok_adc.
        if (cnt_d == NFULL) begin
          state_d = S_OUT;
          dat_d   = acc_sum[AW-1:NAVG_LOG2];
          vld_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign st        = (state_q == S_START);
  assign busy      = (state_q != S_IDLE);
  assign dat_out   = dat_q;
  assign dat_valid = vld_q;
  assign overrun   = ovr_q;
  assign tmo_err   = tmo_q;

`ifdef ADC_PEAK_EN
  logic [11:0] pkw_q, pkw_d, pk_q, pk_d, pk_new;

  assign pk_new = (ADC_dat > pkw_q) ? ADC_dat : pkw_q;

  always_comb begin
    pkw_d = pkw_q;
    pk_d  = pk_q;
    if (state_q == S_LATCH) pkw_d = pk_new;
    if (vld_d) pk_d = pk_new;
    if (state_q == S_OUT || tmo_hit) pkw_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkw_q <= '0;
      pk_q  <= '0;
    end else begin
      pkw_q <= pkw_d;
      pk_q  <= pk_d;
    end
  end

  assign pk_max = pk_q;
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Randomized bench for adc_sample_ctrl against a timeline/queue reference model,
// plus a 16-sample full-scale instance.
module tb_adc_sample_ctrl;
  localparam int DIV       = 100;
  localparam int NAVG_LOG2 = 2;
  localparam int TMO       = 200;
  localparam int WIN       = 1 << NAVG_LOG2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, ok_adc, clr;
  logic [11:0] ADC_dat;
  logic        st, dat_valid, busy, overrun, tmo_err;
  logic [11:0] dat_out;
  logic        en_b, ok_b, st_b, vld_b, busy_b, ovr_b, tmo_b;
  logic [11:0] dat_b;
  logic [11:0] adc_b;
`ifdef ADC_PEAK_EN
  logic [11:0] pk_max, pk_b;
`endif

  adc_sample_ctrl #(.DIV(DIV), .NAVG_LOG2(NAVG_LOG2), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .st(st), .ok_adc(ok_adc), .ADC_dat(ADC_dat),
    .dat_out(dat_out), .dat_valid(dat_valid), .busy(busy), .overrun(overrun),
    .tmo_err(tmo_err),
`ifdef ADC_PEAK_EN
    .pk_max(pk_max),
`endif
    .clr(clr)
  );

  adc_sample_ctrl #(.DIV(64), .NAVG_LOG2(4), .TMO(TMO)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en_b), .st(st_b), .ok_adc(ok_b), .ADC_dat(adc_b),
    .dat_out(dat_b), .dat_valid(vld_b), .busy(busy_b), .overrun(ovr_b),
    .tmo_err(tmo_b),
`ifdef ADC_PEAK_EN
    .pk_max(pk_b),
`endif
    .clr(1'b0)
  );

  int n_chk, n_fail, cyc, mode, rst_hold;
  int ok_q[$];
  logic ok_prev;
  logic [11:0] dtab [4];
  int didx, dir_nv, last_st, b_ok_at, b_nv;

  // Reference model: conversion described by its start cycle and first idle cycle.
  int m_cnt, m_st, m_end, m_lat, m_vcyc, m_vval, m_dat;
  bit m_got, m_ovr, m_tmo;
  int win[$];
`ifdef ADC_PEAK_EN
  int m_pkw, m_vpk, m_pk;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_act(input int c);
    return (m_st >= 0) && (c >= m_st) && (c < m_end);
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_st = -1; m_end = 0; m_lat = -1; m_vcyc = -1; m_vval = 0; m_dat = 0;
    m_got = 0; m_ovr = 0; m_tmo = 0;
    win.delete();
`ifdef ADC_PEAK_EN
    m_pkw = 0; m_vpk = 0; m_pk = 0;
`endif
  endtask

  task automatic m_advance();
    bit act, tick, n_ovr, n_tmo;
    int sum;
    if (!rst_n) begin
      m_reset();
      return;
    end
    act   = m_act(cyc);
    tick  = en && (m_cnt == DIV - 1);
    n_ovr = clr ? 1'b0 : m_ovr;
    n_tmo = clr ? 1'b0 : m_tmo;
    if (act) begin
      if (!m_got && cyc > m_st && ok_adc) begin
        m_got = 1; m_lat = cyc + 1; m_end = cyc + 2;
      end else if (!m_got && cyc == m_st + TMO) begin
        n_tmo = 1; win.delete(); m_end = cyc + 1;
`ifdef ADC_PEAK_EN
        m_pkw = 0;
`endif
      end
      if (cyc == m_lat) begin
        win.push_back(int'(ADC_dat));
`ifdef ADC_PEAK_EN
        if (int'(ADC_dat) > m_pkw) m_pkw = int'(ADC_dat);
`endif
        if (win.size() == WIN) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          m_vval = sum >> NAVG_LOG2;
          m_vcyc = cyc + 1;
          m_end  = cyc + 2;
          win.delete();
`ifdef ADC_PEAK_EN
          m_vpk = m_pkw; m_pkw = 0;
`endif
        end else begin
          m_end = cyc + 1;
        end
      end
    end
    if (tick) begin
      if (act) n_ovr = 1;
      else begin
        m_st = cyc + 1; m_end = cyc + 2 + TMO; m_got = 0; m_lat = -1;
      end
    end
    m_ovr = n_ovr;
    m_tmo = n_tmo;
    m_cnt = en ? ((m_cnt == DIV - 1) ? 0 : m_cnt + 1) : 0;
  endtask

  task automatic step();
    int d, r;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == m_vcyc) begin
      m_dat = m_vval;
`ifdef ADC_PEAK_EN
      m_pk = m_vpk;
`endif
    end
    chk("st", st, int'(cyc == m_st));
    chk("busy", busy, m_act(cyc));
    chk("dat_valid", dat_valid, int'(cyc == m_vcyc));
    chk("dat_out", dat_out, m_dat);
    chk("overrun", overrun, m_ovr);
    chk("tmo_err", tmo_err, m_tmo);
`ifdef ADC_PEAK_EN
    chk("pk_max", pk_max, m_pk);
`endif
    chk("b16_overrun", ovr_b, 0);
    if (vld_b) begin
      b_nv++;
      chk("b16_dat_out", dat_b, 12'hFFF);
`ifdef ADC_PEAK_EN
      chk("b16_pk_max", pk_b, 12'hFFF);
`endif
    end
    if (mode == 0 && dat_valid) dir_nv++;
    if (mode == 0 && st) begin
      if (last_st > 0) chk("st_period", cyc - last_st, DIV);
      last_st = cyc;
    end

    // Stimulus for this cycle
    if (st) begin
      r = $urandom_range(0, 19);
      if (mode == 0)   d = 40;
      else if (r < 12) d = $urandom_range(1, 60);
      else if (r < 15) d = $urandom_range(95, 150);
      else if (r < 17) d = TMO;
      else if (r < 18) d = TMO + 1;
      else             d = 0;
      if (d > 0) ok_q.push_back(cyc + d);
    end
    ok_adc = 1'b0;
    for (int i = ok_q.size() - 1; i >= 0; i--)
      if (ok_q[i] == cyc) begin
        ok_adc = 1'b1;
        ok_q.delete(i);
      end
    if (mode == 0 && ok_prev && didx < 4) begin
      ADC_dat = dtab[didx];
      didx++;
    end else begin
      ADC_dat = 12'($urandom);
    end
    ok_prev = ok_adc;
    if (rst_hold > 0) begin
      rst_n = 1'b0;
      rst_hold--;
    end else if (mode == 1 && $urandom_range(0, 599) == 0) rst_n = 1'b0;
    else rst_n = 1'b1;
    if (mode == 1) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      clr = ($urandom_range(0, 39) == 0);
    end else begin
      en  = 1'b1;
      clr = 1'b0;
    end
    if (st_b) b_ok_at = cyc + 3;
    ok_b = (cyc == b_ok_at);
    m_advance();
  endtask

  initial begin
    bit found;
    n_chk = 0; n_fail = 0; cyc = 0; mode = 0; rst_hold = 2;
    dtab[0] = 12'd100; dtab[1] = 12'd200; dtab[2] = 12'd300; dtab[3] = 12'd401;
    didx = 0; dir_nv = 0; last_st = 0; b_ok_at = -1; b_nv = 0; ok_prev = 1'b0;
    rst_n = 1'b0; en = 1'b0; ok_adc = 1'b0; clr = 1'b0; ADC_dat = '0;
    en_b = 1'b1; ok_b = 1'b0; adc_b = 12'hFFF;
    m_reset();

    repeat (470) step();
    chk("dir_valid_count", dir_nv, 1);
    chk("dir_avg", dat_out, 250);

    mode = 1;
    repeat (20000) step();

    // Reset asserted for one cycle while waiting for ok_adc
    mode = 2;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (st) found = 1;
    end
    chk("reach_start", int'(found), 1);
    rst_hold = 1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_st", st, 0);
    repeat (300) step();

    chk("b16_windows_seen", int'(b_nv > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
